button_conditioner: RTL and testbench

//  Upstream stage of the lock's overall-status FSM. Converts raw, bouncing,

---
 rtl/lock_pkg.sv | 16 +
 rtl/button_conditioner_if.sv | 20 ++
 rtl/debounce_chan.sv | 85 ++++++++
 rtl/button_conditioner.sv | 63 ++++++
 tb/tb_button_conditioner.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared button indices and per-channel debounce state encoding for the lock front end.
package lock_pkg;

    localparam int unsigned BTN_CHANGE = 0;
    localparam int unsigned BTN_ENTER  = 1;
    localparam int unsigned BTN_RESET  = 2;
    localparam int unsigned BTN_CLEAR  = 3;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StPressWait = 2'd1,
        StPressed   = 2'd2,
        StRelWait   = 2'd3
    } deb_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the raw push-button source and the conditioned-level consumer.
interface button_conditioner_if #(
    parameter int unsigned NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse
    );
endinterface

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM and stable-sample counter.
// Outputs are next-cycle values; the top level owns the output registers.
module debounce_chan
    import lock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic press_o,
    output logic level_d_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s2_q) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!s2_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    press_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StPressed: begin
                if (!s2_q) begin
                    state_d = StRelWait;
                    cnt_d   = '0;
                end
            end
            StRelWait: begin
                if (s2_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        // Level stays high through the release debounce window.
        level_d_o = (state_d == StPressed) || (state_d == StRelWait);
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BTN raw push-buttons into clean levels and one-cycle press pulses.
// Define BTN_MUTEX_EN to allow at most one pulse per cycle (enter > change > reset > clear).
module button_conditioner
    import lock_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input logic                 clk,
    input logic                 rst_n,
    button_conditioner_if.slave btn_if
);

    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] level_d, level_q;
    logic [NUM_BTN-1:0] pulse_d, pulse_q;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw_i(btn_if.btn_raw[gi]),
            .press_o  (press[gi]),
            .level_d_o(level_d[gi])
        );
    end

`ifdef BTN_MUTEX_EN
    localparam logic [NUM_BTN-1:0] EnterMask = NUM_BTN'(1) << BTN_ENTER;

    logic [NUM_BTN-1:0] others;

    always_comb begin
        others = press & ~EnterMask;
        // Enter wins outright; the rest resolve lowest-index first via an isolate-lowest-bit trick.
        if ((press & EnterMask) != '0) begin
            pulse_d = EnterMask;
        end else begin
            pulse_d = others & (~others + NUM_BTN'(1));
        end
    end
`else
    always_comb begin
        pulse_d = press;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            pulse_q <= '0;
        end else begin
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign btn_if.btn_level = level_q;
    assign btn_if.btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4: vector table plus corner sequences.
module tb_button_conditioner;

    localparam int unsigned NumBtn = 4;
    localparam int unsigned Deb    = 4;

`ifdef BTN_MUTEX_EN
    localparam logic [3:0] ExpAll = 4'b0010;
    localparam logic [3:0] ExpTwo = 4'b0010;
`else
    localparam logic [3:0] ExpAll = 4'b1111;
    localparam logic [3:0] ExpTwo = 4'b0011;
`endif

    typedef struct {
        string       name;
        logic [3:0]  raw;
        int unsigned cycles;
        logic [3:0]  exp_level;
        logic [3:0]  exp_pulse;
    } vec_t;

    localparam int NumVec = 17;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs [NumVec];

    button_conditioner_if #(.NUM_BTN(NumBtn)) btn_if ();

    button_conditioner #(
        .NUM_BTN        (NumBtn),
        .DEBOUNCE_CYCLES(Deb)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_if(btn_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive raw, advance 'cycles' edges (sampling #1 after each), then check final outputs.
    // Any pulse seen on an earlier edge of the step is also a failure.
    task automatic step(input string name, input logic [3:0] raw, input int unsigned cycles,
                        input logic [3:0] exp_level, input logic [3:0] exp_pulse);
        logic [3:0] early;
        early = 4'b0000;
        btn_if.btn_raw = raw;
        for (int unsigned k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (k + 1 < cycles) early |= btn_if.btn_pulse;
        end
        check4({name, ".early_pulse"}, early, 4'b0000);
        check4({name, ".level"}, btn_if.btn_level, exp_level);
        check4({name, ".pulse"}, btn_if.btn_pulse, exp_pulse);
    endtask

    initial begin
        int pulses;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{"t1_wait",     4'b0010,  6, 4'b0000, 4'b0000};
        vecs[1]  = '{"t1_pulse",    4'b0010,  1, 4'b0010, 4'b0010};
        vecs[2]  = '{"t1_one_cyc",  4'b0010,  1, 4'b0010, 4'b0000};
        vecs[3]  = '{"t1_hold",     4'b0010, 12, 4'b0010, 4'b0000};
        vecs[4]  = '{"t1_relwait",  4'b0000,  6, 4'b0010, 4'b0000};
        vecs[5]  = '{"t1_rel",      4'b0000,  1, 4'b0000, 4'b0000};
        vecs[6]  = '{"t2_short",    4'b0001,  3, 4'b0000, 4'b0000};
        vecs[7]  = '{"t2_low",      4'b0000, 10, 4'b0000, 4'b0000};
        vecs[8]  = '{"t3_wait",     4'b0001,  6, 4'b0000, 4'b0000};
        vecs[9]  = '{"t3_pulse",    4'b0001,  1, 4'b0001, 4'b0001};
        vecs[10] = '{"t3_gap",      4'b0000,  2, 4'b0001, 4'b0000};
        vecs[11] = '{"t3_repress",  4'b0001, 10, 4'b0001, 4'b0000};
        vecs[12] = '{"t3_rel",      4'b0000,  7, 4'b0000, 4'b0000};
        vecs[13] = '{"t4_wait",     4'b1111,  6, 4'b0000, 4'b0000};
        vecs[14] = '{"t4_pulse",    4'b1111,  1, 4'b1111, ExpAll};
        vecs[15] = '{"t4_hold",     4'b1111,  5, 4'b1111, 4'b0000};
        vecs[16] = '{"t4_rel",      4'b0000,  7, 4'b0000, 4'b0000};

        btn_if.btn_raw = 4'b0000;
        rst_n = 1'b0;
        #2;
        check4("reset_level", btn_if.btn_level, 4'b0000);
        check4("reset_pulse", btn_if.btn_pulse, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("idle", 4'b0000, 3, 4'b0000, 4'b0000);

        for (int i = 0; i < NumVec; i++) begin
            step(vecs[i].name, vecs[i].raw, vecs[i].cycles, vecs[i].exp_level,
                 vecs[i].exp_pulse);
        end

        // Reset mid-debounce: enter held and pressed, change still in PRESS_WAIT.
        step("t5_enter", 4'b0010, 7, 4'b0010, 4'b0010);
        step("t5_both", 4'b0011, 4, 4'b0010, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check4("t5_rst_level", btn_if.btn_level, 4'b0000);
        check4("t5_rst_pulse", btn_if.btn_pulse, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check4("t5_in_rst_level", btn_if.btn_level, 4'b0000);
        rst_n = 1'b1;
        step("t5_wait", 4'b0011, 6, 4'b0000, 4'b0000);
        step("t5_pulse", 4'b0011, 1, 4'b0011, ExpTwo);
        step("t5_rel", 4'b0000, 7, 4'b0000, 4'b0000);

        // Long hold, release, second press on reset[2]: two pulses total.
        pulses = 0;
        btn_if.btn_raw = 4'b0100;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) check4("t6_first_pulse", btn_if.btn_pulse, 4'b0100);
            if (btn_if.btn_pulse != 4'b0000) pulses++;
        end
        btn_if.btn_raw = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) check4("t6_level_e5", btn_if.btn_level, 4'b0100);
            if (i == 6) check4("t6_level_e6", btn_if.btn_level, 4'b0000);
            if (btn_if.btn_pulse != 4'b0000) pulses++;
        end
        btn_if.btn_raw = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (btn_if.btn_pulse != 4'b0000) pulses++;
        end
        btn_if.btn_raw = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (btn_if.btn_pulse != 4'b0000) pulses++;
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL t6_pulse_count: got %0d, expected 2", pulses);
        end
        check4("t6_final_level", btn_if.btn_level, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
